// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
// Each accepted word is decoded into register fields, a format code, a
// sign-extended immediate and control bits, then buffered in a DEPTH-entry
// FIFO behind valid/ready handshakes on both sides.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds stricter funct3/funct7
// legality checks and a sticky stall after an illegal entry is accepted.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_alu_src,
    output logic            out_reg_wr,
    output logic            out_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic            reg_wr;
        logic            illegal;
    } entry_t;

    entry_t             dec;
    entry_t             head;
    entry_t             mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               trap;
    logic               push;
    logic               pop;
    logic               bad;
    logic [2:0]         base_fmt;
    logic [2:0]         fmt_sel;
    logic [6:0]         opcode;
    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    // Map the major opcode onto its instruction format; unknown opcodes are illegal
    always_comb begin
        base_fmt = FMT_ILL;
        case (opcode)
            OP_REG:                    base_fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  base_fmt = FMT_I;
            OP_STORE:                  base_fmt = FMT_S;
            OP_BRANCH:                 base_fmt = FMT_B;
            OP_LUI, OP_AUIPC:          base_fmt = FMT_U;
            OP_JAL:                    base_fmt = FMT_J;
            default:                   base_fmt = FMT_ILL;
        endcase
    end

    // Stricter funct3/funct7 legality checks that demote an otherwise valid opcode to illegal
    always_comb begin
        bad = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        case (opcode)
            OP_REG:    bad = ((funct7 != 7'b0000000) && (funct7 != 7'b0100000)) ||
                             ((funct7 == 7'b0100000) && (funct3 != 3'b000) && (funct3 != 3'b101));
            OP_IMM:    bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                             ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                              (funct7 != 7'b0100000));
            OP_JALR:   bad = (funct3 != 3'b000);
            OP_LOAD:   bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OP_STORE:  bad = (funct3 >= 3'b011);
            OP_BRANCH: bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            default:   bad = 1'b0;
        endcase
`endif
        fmt_sel = bad ? FMT_ILL : base_fmt;
    end

    // Assemble the decoded entry; fields a format does not use stay zero
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec.fmt = fmt_sel;
        case (fmt_sel)
            FMT_R: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = funct3;
                dec.funct7 = funct7;
                dec.reg_wr = 1'b1;
            end
            FMT_I: begin
                dec.rd      = in_instr[11:7];
                dec.rs1     = in_instr[19:15];
                dec.funct3  = funct3;
                dec.imm     = XLEN'(imm_i);
                dec.alu_src = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            FMT_S: begin
                dec.rs1     = in_instr[19:15];
                dec.rs2     = in_instr[24:20];
                dec.funct3  = funct3;
                dec.imm     = XLEN'(imm_s);
                dec.alu_src = 1'b1;
            end
            FMT_B: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = funct3;
                dec.imm    = XLEN'(imm_b);
            end
            FMT_U: begin
                dec.rd      = in_instr[11:7];
                dec.imm     = XLEN'(imm_u);
                dec.alu_src = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            FMT_J: begin
                dec.rd      = in_instr[11:7];
                dec.imm     = XLEN'(imm_j);
                dec.alu_src = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            default: begin
                dec.fmt     = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // A full FIFO refuses input even if the head is leaving this cycle; flush blocks both moves
    assign in_ready  = (count < CW'(DEPTH)) && !trap;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Occupancy and wrap-around pointers; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Sticky trap: stall the input once an illegal entry has been accepted, until flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap <= 1'b0;
        end else if (flush) begin
            trap <= 1'b0;
        end else if (push && dec.illegal) begin
            trap <= 1'b1;
        end
    end
`else
    assign trap = 1'b0;
`endif

    // Present the head entry, forced to zero while the FIFO is empty
    always_comb begin
        head = out_valid ? mem[rd_ptr] : '0;
    end

    assign out_pc      = head.pc;
    assign out_fmt     = head.fmt;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_alu_src = head.alu_src;
    assign out_reg_wr  = head.reg_wr;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model that decodes from the RV32I format rules.
module tb_decode_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_alu_src;
    logic        out_reg_wr;
    logic        out_illegal;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_wr;
        logic        illegal;
    } exp_t;

    exp_t model_q[$];
    bit   model_trap = 1'b0;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_alu_src(out_alu_src),
        .out_reg_wr(out_reg_wr), .out_illegal(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode written from the format table: which fields each format carries
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t       e;
        int         f;
        bit         bad;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.pc = pc;
        case (op)
            7'h33:               f = 0;
            7'h13, 7'h03, 7'h67: f = 1;
            7'h23:               f = 2;
            7'h63:               f = 3;
            7'h37, 7'h17:        f = 4;
            7'h6F:               f = 5;
            default:             f = 7;
        endcase
        bad = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (op == 7'h33) bad = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && !(f3 == 0 || f3 == 5));
        if (op == 7'h13 && f3 == 1) bad = (f7 != 7'h00);
        if (op == 7'h13 && f3 == 5) bad = !(f7 == 7'h00 || f7 == 7'h20);
        if (op == 7'h67) bad = (f3 != 0);
        if (op == 7'h03) bad = (f3 == 3 || f3 == 6 || f3 == 7);
        if (op == 7'h23) bad = (f3 >= 3);
        if (op == 7'h63) bad = (f3 == 2 || f3 == 3);
`endif
        if (bad) f = 7;
        e.fmt     = 3'(f);
        e.illegal = (f == 7);
        e.rd      = (f == 0 || f == 1 || f == 4 || f == 5) ? w[11:7]  : 5'd0;
        e.rs1     = (f >= 0 && f <= 3)                     ? w[19:15] : 5'd0;
        e.rs2     = (f == 0 || f == 2 || f == 3)           ? w[24:20] : 5'd0;
        e.funct3  = (f >= 0 && f <= 3)                     ? f3       : 3'd0;
        e.funct7  = (f == 0)                               ? f7       : 7'd0;
        e.alu_src = (f == 1 || f == 2 || f == 4 || f == 5);
        e.reg_wr  = (f == 0 || f == 1 || f == 4 || f == 5);
        case (f)
            1: e.imm = {{20{w[31]}}, w[31:20]};
            2: e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            3: e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            4: e.imm = {w[31:12], 12'b0};
            5: e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    // Single comparison with a pass/fail tally
    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Mid-cycle model step: compare DUT against model, then advance the model by one edge
    always @(negedge clk) begin
        exp_t exp_head;
        bit   exp_rdy;
        exp_rdy  = (model_q.size() < DEPTH) && !model_trap;
        exp_head = (model_q.size() > 0) ? model_q[0] : '0;
        if (rst) begin
            model_q.delete();
            model_trap = 1'b0;
            exp_rdy  = 1'b1;
            exp_head = '0;
        end
        check_output("in_ready", in_ready, exp_rdy);
        check_output("out_valid", out_valid, (model_q.size() > 0));
        check_output("head_entry",
                     {out_pc, out_fmt, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                      out_imm, out_alu_src, out_reg_wr, out_illegal}, exp_head);
        if (!rst) begin
            if (flush) begin
                model_q.delete();
                model_trap = 1'b0;
            end else begin
                if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
                if (in_valid && exp_rdy) begin
                    exp_t e;
                    e = model_decode(in_instr, in_pc);
                    model_q.push_back(e);
`ifdef DECODE_ILLEGAL_TRAP_EN
                    if (e.illegal) model_trap = 1'b1;
`endif
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge
    task automatic apply_stimulus(input bit v, input logic [31:0] w, input logic [31:0] pc,
                                  input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        int          k;
        int          r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 9) w[6:0] = ops[k];
        r = $urandom_range(0, 3);
        if (r == 0) w[31:25] = 7'h00;
        if (r == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    bit trap_mode;

    initial begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        trap_mode = 1'b1;
`else
        trap_mode = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_out_valid", out_valid, 1'b0);
        check_output("reset_in_ready", in_ready, 1'b1);
        check_output("reset_out_imm", out_imm, 32'd0);
        rst = 1'b0;

        $display("[TB] addi x1,x0,5");
        apply_stimulus(1, 32'h00500093, 32'h100, 1, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("addi_valid", out_valid, 1'b1);
        check_output("addi_fmt", out_fmt, 3'd1);
        check_output("addi_rd", out_rd, 5'd1);
        check_output("addi_rs1", out_rs1, 5'd0);
        check_output("addi_imm", out_imm, 32'd5);
        check_output("addi_ctrl", {out_alu_src, out_reg_wr}, 2'b11);

        $display("[TB] beq x0,x0,-4");
        apply_stimulus(1, 32'hFE000EE3, 32'h104, 1, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("beq_fmt", out_fmt, 3'd3);
        check_output("beq_imm", out_imm, 32'hFFFFFFFC);
        check_output("beq_rd", out_rd, 5'd0);
        check_output("beq_ctrl", {out_alu_src, out_reg_wr}, 2'b00);

        $display("[TB] lui x5,0x12345");
        apply_stimulus(1, 32'h123452B7, 32'h108, 1, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("lui_fmt", out_fmt, 3'd4);
        check_output("lui_rd", out_rd, 5'd5);
        check_output("lui_imm", out_imm, 32'h12345000);
        check_output("lui_rs", {out_rs1, out_rs2}, 10'd0);

        $display("[TB] fill, stall and drain");
        apply_stimulus(1, 32'h00100093, 32'h200, 0, 0);
        apply_stimulus(1, 32'h00200113, 32'h204, 0, 0);
        apply_stimulus(1, 32'h00300193, 32'h208, 0, 0);
        check_output("full_in_ready", in_ready, 1'b0);
        check_output("full_head_pc", out_pc, 32'h200);
        apply_stimulus(1, 32'h00300193, 32'h208, 1, 0);
        apply_stimulus(1, 32'h00300193, 32'h208, 1, 0);
        check_output("drain1_pc", out_pc, 32'h204);
        check_output("drain1_in_ready", in_ready, 1'b1);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("drain2_pc", out_pc, 32'h208);
        check_output("drain2_rd", out_rd, 5'd3);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("drained_valid", out_valid, 1'b0);

        $display("[TB] flush and async reset");
        apply_stimulus(1, 32'h00400213, 32'h300, 0, 0);
        apply_stimulus(1, 32'h00500293, 32'h304, 0, 0);
        apply_stimulus(1, 32'h00600313, 32'h308, 0, 1);
        apply_stimulus(0, 32'h0, 32'h0, 0, 0);
        check_output("flush_valid", out_valid, 1'b0);
        check_output("flush_in_ready", in_ready, 1'b1);
        apply_stimulus(1, 32'h00700393, 32'h30C, 0, 0);
        apply_stimulus(1, 32'h00800413, 32'h310, 0, 0);
        apply_stimulus(0, 32'h0, 32'h0, 0, 0);
        check_output("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_valid", out_valid, 1'b0);
        check_output("async_rst_pc", out_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] illegal opcode");
        apply_stimulus(1, 32'h0000007F, 32'h400, 0, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("ill_fmt", out_fmt, 3'd7);
        check_output("ill_flag", out_illegal, 1'b1);
        check_output("ill_imm", out_imm, 32'd0);
        check_output("ill_in_ready", in_ready, !trap_mode);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        check_output("ill_sticky", in_ready, !trap_mode);
        apply_stimulus(0, 32'h0, 32'h0, 1, 1);
        apply_stimulus(1, 32'h00001067, 32'h404, 0, 0);
        apply_stimulus(0, 32'h0, 32'h0, 0, 0);
        check_output("jalr_f3_fmt", out_fmt, trap_mode ? 3'd7 : 3'd1);
        check_output("jalr_f3_illegal", out_illegal, trap_mode);
        apply_stimulus(0, 32'h0, 32'h0, 1, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 32'h0, 32'h0, 1, 0);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
